eth_rx_writer: RTL and testbench

ETH_RX_WRITER -- requirements
Module: eth_rx_writer

---
 rtl/eth_rx_writer.sv | 119 +++++++++++
 tb/tb_eth_rx_writer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_writer.sv
// Ethernet receive writer: assembles MII nibbles into 32-bit words and writes
// them to the arbiter's Ethernet write port, with per-frame word limit and overflow.
module eth_rx_writer #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  max_words_i,
    input  logic              rx_dv_i,
    input  logic [3:0]        rxd_i,
    output logic [ADDR_W-1:0] ewr_addr_o,
    output logic [31:0]       ewr_data_o,
    output logic              ewr_write_o,
    output logic              frame_done_o,
    output logic [CNT_W-1:0]  frame_words_o,
    output logic              overflow_o,
    output logic              busy_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE = 1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       sr;
    logic [2:0]        nib_cnt;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  limit;
    logic              prev_dv;
    logic [31:0]       shifted;
    logic [4:0]        flush_shift;
    logic [31:0]       flush_data;
    logic              room;

    assign shifted     = {rxd_i, sr[31:4]};
    // 4*(8-nib_cnt); nib_cnt is never 0 in FLUSH so the 3-bit wrap is exact
    assign flush_shift = {3'd0 - nib_cnt, 2'b00};
    assign flush_data  = sr >> flush_shift;
    assign room        = (word_cnt < limit);
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            sr            <= '0;
            nib_cnt       <= '0;
            word_cnt      <= '0;
            limit         <= '0;
            prev_dv       <= 1'b1;
            ewr_addr_o    <= '0;
            ewr_data_o    <= '0;
            ewr_write_o   <= 1'b0;
            frame_done_o  <= 1'b0;
            frame_words_o <= '0;
            overflow_o    <= 1'b0;
        end else begin
            prev_dv      <= rx_dv_i;
            ewr_write_o  <= 1'b0;
            frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_dv_i && !prev_dv) begin
                        ptr        <= base_addr_i;
                        limit      <= max_words_i;
                        word_cnt   <= '0;
                        overflow_o <= 1'b0;
                        sr         <= {rxd_i, 28'h0};
                        nib_cnt    <= 3'd1;
                        state      <= RECV;
                    end
                end
                RECV: begin
                    if (rx_dv_i) begin
                        sr      <= shifted;
                        nib_cnt <= nib_cnt + 3'd1;
                        if (nib_cnt == 3'd7) begin
                            if (room) begin
                                ewr_data_o  <= shifted;
                                ewr_addr_o  <= ptr;
                                ewr_write_o <= 1'b1;
                                ptr         <= ptr + PTR_ONE;
                                word_cnt    <= word_cnt + CNT_ONE;
                            end else begin
                                overflow_o <= 1'b1;
                            end
                        end
                    end else if (nib_cnt != 3'd0 && room) begin
                        state <= FLUSH;
                    end else begin
                        state <= DONE;
                    end
                end
                FLUSH: begin
                    ewr_data_o  <= flush_data;
                    ewr_addr_o  <= ptr;
                    ewr_write_o <= 1'b1;
                    ptr         <= ptr + PTR_ONE;
                    word_cnt    <= word_cnt + CNT_ONE;
                    state       <= DONE;
                end
                DONE: begin
                    frame_done_o  <= 1'b1;
                    frame_words_o <= word_cnt;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_writer.sv
// Directed bench for eth_rx_writer: nibble frames driven on the falling edge,
// write port logged shortly after each rising edge, checks with immediate assertions.
module tb_eth_rx_writer;

    logic        clk;
    logic        rst;
    logic [8:0]  base_addr_i;
    logic [6:0]  max_words_i;
    logic        rx_dv_i;
    logic [3:0]  rxd_i;
    logic [8:0]  ewr_addr_o;
    logic [31:0] ewr_data_o;
    logic        ewr_write_o;
    logic        frame_done_o;
    logic [6:0]  frame_words_o;
    logic        overflow_o;
    logic        busy_o;

    int tests = 0;
    int fails = 0;

    logic [8:0]  wa[$];
    logic [31:0] wd[$];
    int          done_cnt = 0;
    int          b2b = 0;
    logic        prev_wr = 1'b0;

    eth_rx_writer #(.ADDR_W(9), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .base_addr_i(base_addr_i), .max_words_i(max_words_i),
        .rx_dv_i(rx_dv_i), .rxd_i(rxd_i),
        .ewr_addr_o(ewr_addr_o), .ewr_data_o(ewr_data_o), .ewr_write_o(ewr_write_o),
        .frame_done_o(frame_done_o), .frame_words_o(frame_words_o),
        .overflow_o(overflow_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (ewr_write_o) begin
                wa.push_back(ewr_addr_o);
                wd.push_back(ewr_data_o);
                if (prev_wr) b2b++;
            end
            if (frame_done_o) done_cnt++;
        end
        prev_wr = ewr_write_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        @(negedge clk);
        rx_dv_i = 1'b1;
        rxd_i   = v;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_dv_i = 1'b0;
            rxd_i   = 4'h0;
        end
    endtask

    task automatic begin_test(input logic [8:0] base, input logic [6:0] maxw);
        wa.delete();
        wd.delete();
        done_cnt    = 0;
        base_addr_i = base;
        max_words_i = maxw;
    endtask

    // drop rx_dv and wait (bounded) for the frame_done pulse
    task automatic end_frame(input string tag);
        int n = 0;
        @(negedge clk);
        rx_dv_i = 1'b0;
        while (done_cnt == 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done_cnt, 1);
    endtask

    task automatic send_seq(input int first, input int count);
        for (int i = 0; i < count; i++) drive(4'((first + i) & 15));
    endtask

    initial begin
        rst = 1'b1; rx_dv_i = 1'b0; rxd_i = 4'h0;
        base_addr_i = '0; max_words_i = '0;
        repeat (3) @(negedge clk);
        check("rst_write", ewr_write_o, 0);
        check("rst_addr", ewr_addr_o, 0);
        check("rst_data", ewr_data_o, 0);
        check("rst_done", frame_done_o, 0);
        check("rst_words", frame_words_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_busy", busy_o, 0);
        rst = 1'b0;
        idle_cycles(3);

        // two full words
        begin_test(9'h040, 7'd8);
        send_seq(0, 16);
        end_frame("t1");
        check("t1_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            check("t1_a0", wa[0], 9'h040); check("t1_d0", wd[0], 32'h76543210);
            check("t1_a1", wa[1], 9'h041); check("t1_d1", wd[1], 32'hFEDCBA98);
        end
        check("t1_words", frame_words_o, 2);
        check("t1_ovf", overflow_o, 0);
        idle_cycles(1);
        check("t1_busy", busy_o, 0);

        // partial word flush
        begin_test(9'h010, 7'd8);
        send_seq(1, 3);
        end_frame("t2");
        check("t2_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            check("t2_a0", wa[0], 9'h010); check("t2_d0", wd[0], 32'h00000321);
        end
        check("t2_words", frame_words_o, 1);
        idle_cycles(2);

        // limit 1 with 2 words: overflow
        begin_test(9'h000, 7'd1);
        send_seq(0, 16);
        end_frame("t3");
        check("t3_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            check("t3_a0", wa[0], 9'h000); check("t3_d0", wd[0], 32'h76543210);
        end
        check("t3_ovf", overflow_o, 1);
        check("t3_words", frame_words_o, 1);
        idle_cycles(2);
        check("t3_ovf_hold", overflow_o, 1);

        // pointer wrap; overflow cleared at frame start
        begin_test(9'h1FF, 7'd8);
        drive(4'h0);
        drive(4'h1);
        check("t4_ovf_clr", overflow_o, 0);
        check("t4_busy", busy_o, 1);
        send_seq(2, 14);
        end_frame("t4");
        check("t4_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            check("t4_a0", wa[0], 9'h1FF); check("t4_d0", wd[0], 32'h76543210);
            check("t4_a1", wa[1], 9'h000); check("t4_d1", wd[1], 32'hFEDCBA98);
        end
        idle_cycles(2);

        // reset mid-frame with rx_dv held high
        begin_test(9'h020, 7'd8);
        send_seq(0, 5);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_rst_busy", busy_o, 0);
        check("t5_rst_write", ewr_write_o, 0);
        check("t5_rst_data", ewr_data_o, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_nostart", busy_o, 0);
        check("t5_nwr", wa.size(), 0);
        check("t5_ndone", done_cnt, 0);
        idle_cycles(1);
        send_seq(8, 8);
        end_frame("t5");
        check("t5_nwr2", wa.size(), 1);
        if (wa.size() == 1) begin
            check("t5_a0", wa[0], 9'h020); check("t5_d0", wd[0], 32'hFEDCBA98);
        end
        check("t5_words", frame_words_o, 1);
        idle_cycles(2);

        // second burst during FLUSH/DONE is ignored
        begin_test(9'h030, 7'd8);
        send_seq(10, 3);
        idle_cycles(1);
        send_seq(5, 4);
        idle_cycles(4);
        check("t6_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            check("t6_a0", wa[0], 9'h030); check("t6_d0", wd[0], 32'h00000CBA);
        end
        check("t6_ndone", done_cnt, 1);
        check("t6_words", frame_words_o, 1);
        check("t6_busy", busy_o, 0);
        begin_test(9'h031, 7'd8);
        send_seq(1, 8);
        end_frame("t6b");
        check("t6b_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            check("t6b_a0", wa[0], 9'h031); check("t6b_d0", wd[0], 32'h87654321);
        end
        idle_cycles(2);

        // full word then flush of trailing nibble
        begin_test(9'h060, 7'd8);
        send_seq(0, 9);
        end_frame("t7");
        check("t7_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            check("t7_d0", wd[0], 32'h76543210);
            check("t7_a1", wa[1], 9'h061); check("t7_d1", wd[1], 32'h00000008);
        end
        check("t7_words", frame_words_o, 2);
        idle_cycles(2);

        // limit 0: full word overflows, no writes
        begin_test(9'h050, 7'd0);
        send_seq(3, 8);
        end_frame("t8");
        check("t8_nwr", wa.size(), 0);
        check("t8_ovf", overflow_o, 1);
        check("t8_words", frame_words_o, 0);
        idle_cycles(2);

        // limit 0 with partial word: no flush, no overflow
        begin_test(9'h050, 7'd0);
        send_seq(3, 3);
        end_frame("t9");
        check("t9_nwr", wa.size(), 0);
        check("t9_ovf", overflow_o, 0);
        check("t9_words", frame_words_o, 0);
        idle_cycles(2);

        check("b2b_writes", b2b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
